// File: rtl/ram_fill_check.sv
// Fill/check engine for a single-port block RAM: writes addr+base to every word, reads it back, counts mismatches.
// Optional build macro RAM_FILL_CHECK_LOOP_EN: DONE lasts one cycle and the next pass starts automatically with base+1.
module ram_fill_check #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [7:0]        err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  state_t              state;
  logic [DATA_W-1:0]   base;
  logic                cmp_v;
  logic [DATA_W-1:0]   cmp_exp;
  logic [ADDR_W-1:0]   cmp_addr;
  logic                go;
  logic [DATA_W-1:0]   next_base;

  assign state_dbg = state;

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] w;
    w = '0;
    w[ADDR_W-1:0] = a;
    return w + b;
  endfunction

  // A pass begins from IDLE or DONE; an explicit start always restores base 0.
  always_comb begin
    go        = 1'b0;
    next_base = '0;
    case (state)
      S_IDLE: go = start;
      S_DONE: begin
`ifdef RAM_FILL_CHECK_LOOP_EN
        go        = 1'b1;
        next_base = start ? '0 : base + DATA_W'(1);
`else
        go        = start;
`endif
      end
      default: go = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      ram_we         <= 1'b0;
      ram_addr       <= '0;
      ram_din        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      err_count      <= 8'd0;
      first_err_addr <= '0;
      base           <= '0;
      cmp_v          <= 1'b0;
      cmp_exp        <= '0;
      cmp_addr       <= '0;
    end else begin
      // Read data arrives one cycle after its address; compare against the word registered then.
      cmp_v <= 1'b0;
      if (cmp_v && (ram_dout != cmp_exp)) begin
        error <= 1'b1;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        if (err_count == 8'd0) first_err_addr <= cmp_addr;
      end

      if (go) begin
        state          <= S_WRITE;
        base           <= next_base;
        ram_we         <= 1'b1;
        ram_addr       <= '0;
        ram_din        <= next_base;
        busy           <= 1'b1;
        done           <= 1'b0;
        error          <= 1'b0;
        err_count      <= 8'd0;
        first_err_addr <= '0;
      end else begin
        case (state)
          S_WRITE: begin
            if (ram_addr == LAST_ADDR) begin
              state    <= S_READ;
              ram_we   <= 1'b0;
              ram_addr <= '0;
              ram_din  <= '0;
            end else begin
              ram_addr <= ram_addr + ADDR_ONE;
              ram_din  <= pattern(ram_addr + ADDR_ONE, base);
            end
          end
          S_READ: begin
            cmp_v    <= 1'b1;
            cmp_exp  <= pattern(ram_addr, base);
            cmp_addr <= ram_addr;
            if (ram_addr == LAST_ADDR) begin
              state    <= S_DRAIN;
              ram_addr <= '0;
            end else begin
              ram_addr <= ram_addr + ADDR_ONE;
            end
          end
          S_DRAIN: begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ram_fill_check.sv
// Bench for ram_fill_check: behavioural RAM models, write scoreboard, pass timing and error-statistics checks.
module tb_ram_fill_check;

  localparam int ST_IDLE = 0;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       ram_we;
  logic [4:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout = 8'h00;
  logic       busy, done, error;
  logic [7:0] err_count;
  logic [4:0] first_err_addr;
  logic [2:0] state_dbg;

  logic       start9 = 1'b0;
  logic       ram_we9;
  logic [8:0] ram_addr9, ram_din9, first_err_addr9;
  logic [8:0] ram_dout9 = 9'h1FF;
  logic       busy9, done9, error9;
  logic [7:0] err_count9;
  logic [2:0] state_dbg9;

  int n_cmp = 0;
  int n_bad = 0;
  logic        sb_on = 1'b0;
  logic [12:0] exp_q[$];
  logic [1:0]  ram_mode = 2'd0;
  logic [7:0]  mem [0:31];

  ram_fill_check #(.ADDR_W(5), .DATA_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout), .busy(busy), .done(done), .error(error),
    .err_count(err_count), .first_err_addr(first_err_addr), .state_dbg(state_dbg)
  );

  ram_fill_check #(.ADDR_W(9), .DATA_W(9)) dut9 (
    .clk(clk), .reset_n(reset_n), .start(start9), .ram_we(ram_we9), .ram_addr(ram_addr9),
    .ram_din(ram_din9), .ram_dout(ram_dout9), .busy(busy9), .done(done9), .error(error9),
    .err_count(err_count9), .first_err_addr(first_err_addr9), .state_dbg(state_dbg9)
  );

  // clock / reset
  always #10 clk = ~clk;

  // RAM model: mode 0 ideal, 1 bit 0 of address 5 stuck at 0, 2 always reads 0xFF
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    if (ram_mode == 2'd2)                        ram_dout <= 8'hFF;
    else if (ram_mode == 2'd1 && ram_addr == 5)  ram_dout <= mem[ram_addr] & 8'hFE;
    else                                         ram_dout <= mem[ram_addr];
  end

  // scoreboard: every observed write must match the head of the expected queue
  always @(negedge clk) begin
    if (sb_on && reset_n && ram_we) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got addr=%0d din=%h, required no write", ram_addr, ram_din);
      end else begin
        logic [12:0] e;
        e = exp_q.pop_front();
        if ({ram_addr, ram_din} !== e) begin
          n_bad++;
          $display("FAIL write_data: got addr=%0d din=%h, required addr=%0d din=%h",
                   ram_addr, ram_din, e[12:8], e[7:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic push_pass(input logic [7:0] base, input int upto);
    for (int a = 0; a <= upto; a++) begin
      logic [7:0] d;
      d = 8'(a) + base;
      exp_q.push_back({5'(a), d});
    end
  endtask

  // Pulse start; n counts clock edges with the start-sampling edge as 1, until done is seen.
  task automatic run_pass(input int p1, input int p2, output int n);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
      start = (n == p1 || n == p2);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({ram_we, ram_addr, ram_din, busy, done, error, err_count, first_err_addr} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got we=%b addr=%0d din=%h busy=%b done=%b err=%b cnt=%0d first=%0d, required all 0",
               ram_we, ram_addr, ram_din, busy, done, error, err_count, first_err_addr);
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (state_dbg !== 3'(ST_IDLE) || busy !== 1'b0 || ram_we !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: got state=%0d busy=%b we=%b, required state=0 busy=0 we=0", state_dbg, busy, ram_we);
    end
  endtask

  task automatic test_ideal;
    int n;
    ram_mode = 2'd0;
    sb_on = 1'b1;
    push_pass(8'h00, 31);
    run_pass(-1, -1, n);
    n_cmp++;
    if (n !== 66) begin n_bad++; $display("FAIL ideal_done_cycle: got %0d, required 66", n); end
    n_cmp++;
    if (error !== 1'b0 || err_count !== 8'd0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL ideal_status: got err=%b cnt=%0d busy=%b, required 0 0 0", error, err_count, busy);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL ideal_writes_left: got %0d, required 0", exp_q.size()); end
    sb_on = 1'b0;
  endtask

  task automatic test_stuck_bit;
    int n;
    ram_mode = 2'd1;
    sb_on = 1'b1;
    push_pass(8'h00, 31);
    run_pass(-1, -1, n);
    n_cmp++;
    if (n !== 66) begin n_bad++; $display("FAIL stuck_done_cycle: got %0d, required 66", n); end
    n_cmp++;
    if (error !== 1'b1 || err_count !== 8'd1 || first_err_addr !== 5'd5) begin
      n_bad++;
      $display("FAIL stuck_status: got err=%b cnt=%0d first=%0d, required 1 1 5", error, err_count, first_err_addr);
    end
    // results must persist while waiting in DONE
    repeat (5) @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || error !== 1'b1 || err_count !== 8'd1 || first_err_addr !== 5'd5 || ram_we !== 1'b0) begin
      n_bad++;
      $display("FAIL stuck_hold: got done=%b err=%b cnt=%0d first=%0d we=%b, required 1 1 1 5 0",
               done, error, err_count, first_err_addr, ram_we);
    end
    sb_on = 1'b0;
  endtask

  task automatic test_ignore_start;
    int n, p1, p2;
    ram_mode = 2'd0;
    sb_on = 1'b1;
    p1 = $urandom_range(3, 30);
    p2 = $urandom_range(35, 62);
    push_pass(8'h00, 31);
    run_pass(p1, p2, n);
    n_cmp++;
    if (n !== 66) begin n_bad++; $display("FAIL ignore_start_cycle: got %0d, required 66 (pulses %0d %0d)", n, p1, p2); end
    n_cmp++;
    if (error !== 1'b0 || err_count !== 8'd0 || first_err_addr !== 5'd0) begin
      n_bad++;
      $display("FAIL restart_cleared: got err=%b cnt=%0d first=%0d, required 0 0 0", error, err_count, first_err_addr);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL ignore_writes_left: got %0d, required 0", exp_q.size()); end
    sb_on = 1'b0;
  endtask

  task automatic test_all_ff;
    int n;
    ram_mode = 2'd2;
    sb_on = 1'b1;
    push_pass(8'h00, 31);
    run_pass(-1, -1, n);
    n_cmp++;
    if (n !== 66 || error !== 1'b1 || err_count !== 8'd32 || first_err_addr !== 5'd0) begin
      n_bad++;
      $display("FAIL all_ff: got n=%0d err=%b cnt=%0d first=%0d, required 66 1 32 0", n, error, err_count, first_err_addr);
    end
    sb_on = 1'b0;
  endtask

  task automatic test_saturate;
    int n;
    @(negedge clk); start9 = 1'b1;
    @(negedge clk); start9 = 1'b0;
    n = 1;
    while (done9 !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    n_cmp++;
    if (n !== 1026 || err_count9 !== 8'd255 || first_err_addr9 !== 9'd0 || error9 !== 1'b1) begin
      n_bad++;
      $display("FAIL saturate: got n=%0d cnt=%0d first=%0d err=%b, required 1026 255 0 1", n, err_count9, first_err_addr9, error9);
    end
  endtask

  task automatic test_reset_mid_write;
    int n;
    ram_mode = 2'd0;
    sb_on = 1'b1;
    push_pass(8'h00, 10);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!(ram_we === 1'b1 && ram_addr === 5'd10) && n < 100) begin @(negedge clk); n++; end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (n >= 100 || ram_we !== 1'b0 || state_dbg !== 3'(ST_IDLE) || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: got n=%0d we=%b state=%0d busy=%b, required we=0 state=0 busy=0", n, ram_we, state_dbg, busy);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL reset_mid_writes_left: got %0d, required 0", exp_q.size()); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    n_cmp++;
    if (state_dbg !== 3'(ST_IDLE) || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_stays_idle: got state=%0d done=%b, required 0 0", state_dbg, done);
    end
    sb_on = 1'b0;
  endtask

`ifdef RAM_FILL_CHECK_LOOP_EN
  task automatic test_loop;
    int n;
    ram_mode = 2'd0;
    sb_on = 1'b1;
    push_pass(8'h00, 31);
    run_pass(-1, -1, n);
    n_cmp++;
    if (n !== 66) begin n_bad++; $display("FAIL loop_first_cycle: got %0d, required 66", n); end
    for (int p = 1; p <= 2; p++) begin
      push_pass(8'(p), 31);
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0) begin n_bad++; $display("FAIL loop_done_width: got done=%b, required 0", done); end
      n = 2;
      while (done !== 1'b1 && n < 300) begin @(negedge clk); n++; end
      n_cmp++;
      if (n !== 67 || error !== 1'b0 || err_count !== 8'd0) begin
        n_bad++;
        $display("FAIL loop_pass%0d: got period=%0d err=%b cnt=%0d, required 67 0 0", p, n, error, err_count);
      end
    end
    sb_on = 1'b0;
    reset_n = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL loop_writes_left: got %0d, required 0", exp_q.size()); end
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
`ifdef RAM_FILL_CHECK_LOOP_EN
    test_loop();
    test_reset_mid_write();
`else
    test_ideal();
    test_stuck_bit();
    test_ignore_start();
    test_all_ff();
    test_saturate();
    test_reset_mid_write();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
